arp_table_arbiter: RTL and testbench

- Shares the single ARP table register read/write port pair between NUM_REQ independent requesters, such as the host register block and an ARP-learning/aging engine.
- Each requester issues read or write transactions. The arbiter grants one at a time, round-robin, and drives the table's rd/wr request lines.
- It waits for the table's ack, then returns the read data and a one-cycle ack to the granted requester.
- It sits between the requesters and the ARP CAM/LUT state machine in the router output-port-lookup.

---
 rtl/arp_arb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/arp_table_arbiter.sv | 124 ++++++++++++
 tb/tb_arp_table_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_arb_pkg.sv
// arp_arb_pkg: shared FSM encoding, field widths and a ceil-log2 helper for the ARP table arbiter.
package arp_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int MAC_WIDTH = 48;
  localparam int IP_WIDTH = 32;
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; first set request at or after ptr, wrapping.
module rr_arbiter
  import arp_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = log2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    j = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
    grant = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/arp_table_arbiter.sv
// arp_table_arbiter: round-robin sharing of the ARP table rd/wr port pair between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining ARP_TABLE_ARBITER_TIMEOUT_EN.
module arp_table_arbiter
  import arp_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LUT_DEPTH = 32,
  parameter int LUT_DEPTH_BITS = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_is_wr,
  input  logic [NUM_REQ*LUT_DEPTH_BITS-1:0] req_addr,
  input  logic [NUM_REQ*MAC_WIDTH-1:0]      req_wr_mac,
  input  logic [NUM_REQ*IP_WIDTH-1:0]       req_wr_ip,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic                              req_err,
  output logic [MAC_WIDTH-1:0]              rsp_rd_mac,
  output logic [IP_WIDTH-1:0]               rsp_rd_ip,
  output logic [LUT_DEPTH_BITS-1:0]         arp_rd_addr,
  output logic                              arp_rd_req,
  input  logic [MAC_WIDTH-1:0]              arp_rd_mac,
  input  logic [IP_WIDTH-1:0]               arp_rd_ip,
  input  logic                              arp_rd_ack,
  output logic [LUT_DEPTH_BITS-1:0]         arp_wr_addr,
  output logic                              arp_wr_req,
  output logic [MAC_WIDTH-1:0]              arp_wr_mac,
  output logic [IP_WIDTH-1:0]               arp_wr_ip,
  input  logic                              arp_wr_ack
);
  localparam int IW = log2(NUM_REQ);
  localparam int AW = LUT_DEPTH_BITS;

  if (AW != log2(LUT_DEPTH) || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("arp_table_arbiter: inconsistent parameters");
  end

  state_t state, next;
  logic [IW-1:0] ptr, gnt, pick;
  logic [NUM_REQ-1:0] pick_oh, gnt_oh;
  logic any, is_wr, hit, expire, start, done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(pick_oh),
    .idx  (pick),
    .any  (any)
  );

  assign hit = is_wr ? arp_wr_ack : arp_rd_ack;
  assign start = (state == IDLE) && any;
  assign done = (state == WAIT) && (hit || expire);

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = any ? ISSUE : IDLE;
      ISSUE:   next = WAIT;
      WAIT:    next = (hit || expire) ? RESP : WAIT;
      default: next = IDLE;
    endcase
  end

  // Request fields are captured straight into the table-facing registers and held until the next grant.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ptr <= '0;
      gnt <= '0;
      gnt_oh <= '0;
      is_wr <= 1'b0;
      req_ack <= '0;
      rsp_rd_mac <= '0;
      rsp_rd_ip <= '0;
      arp_rd_addr <= '0;
      arp_rd_req <= 1'b0;
      arp_wr_addr <= '0;
      arp_wr_req <= 1'b0;
      arp_wr_mac <= '0;
      arp_wr_ip <= '0;
    end else begin
      arp_rd_req <= start && !req_is_wr[pick];
      arp_wr_req <= start && req_is_wr[pick];
      req_ack <= done ? gnt_oh : '0;
      if (start) begin
        gnt <= pick;
        gnt_oh <= pick_oh;
        is_wr <= req_is_wr[pick];
        arp_rd_addr <= req_addr[int'(pick)*AW +: AW];
        arp_wr_addr <= req_addr[int'(pick)*AW +: AW];
        arp_wr_mac <= req_wr_mac[int'(pick)*MAC_WIDTH +: MAC_WIDTH];
        arp_wr_ip <= req_wr_ip[int'(pick)*IP_WIDTH +: IP_WIDTH];
      end
      if (done && !is_wr) begin
        rsp_rd_mac <= hit ? arp_rd_mac : '0;
        rsp_rd_ip <= hit ? arp_rd_ip : '0;
      end
      if (state == RESP) ptr <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
    end

`ifdef ARP_TABLE_ARBITER_TIMEOUT_EN
  localparam int CW = log2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  assign expire = cnt == CW'(TIMEOUT_CYCLES - 1);
  // The counter sits at zero outside WAIT, so it is already cleared on WAIT entry.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      req_err <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      req_err <= done && !hit;
    end
`else
  assign expire = 1'b0;
  assign req_err = 1'b0;
`endif
endmodule

// File: tb/tb_arp_table_arbiter.sv
// tb_arp_table_arbiter: table vectors, hand-written corner sequences and randomized traffic
// checked against a round-robin/table model for arp_table_arbiter.
module tb_arp_table_arbiter;
  localparam int N = 2;
  localparam int AW = 5;

  typedef struct {
    int          r;
    bit          wr;
    logic [4:0]  addr;
    logic [47:0] mac;
    logic [31:0] ip;
    int          dly;
    bit          stray;
    logic [47:0] tmac;
    logic [31:0] tip;
    logic [1:0]  eack;
    logic [47:0] emac;
    logic [31:0] eip;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  logic [N-1:0] req_valid, req_is_wr, req_ack;
  logic [N*AW-1:0] req_addr;
  logic [N*48-1:0] req_wr_mac;
  logic [N*32-1:0] req_wr_ip;
  logic req_err, arp_rd_req, arp_wr_req, arp_rd_ack, arp_wr_ack;
  logic [47:0] rsp_rd_mac, arp_rd_mac, arp_wr_mac;
  logic [31:0] rsp_rd_ip, arp_rd_ip, arp_wr_ip;
  logic [AW-1:0] arp_rd_addr, arp_wr_addr;

  int checks = 0;
  int fails = 0;
  int ptr_m = 0;
  logic [79:0] last_rsp = '0;
  logic [79:0] mem [32];
  int order [$];
  logic tx_wr [N];
  logic [4:0] tx_addr [N];
  logic [47:0] tx_mac [N];
  logic [31:0] tx_ip [N];
  vec_t vecs [6];

  always #5 clk = ~clk;

  arp_table_arbiter #(.NUM_REQ(N), .LUT_DEPTH(32), .LUT_DEPTH_BITS(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_is_wr(req_is_wr), .req_addr(req_addr),
    .req_wr_mac(req_wr_mac), .req_wr_ip(req_wr_ip),
    .req_ack(req_ack), .req_err(req_err), .rsp_rd_mac(rsp_rd_mac), .rsp_rd_ip(rsp_rd_ip),
    .arp_rd_addr(arp_rd_addr), .arp_rd_req(arp_rd_req), .arp_rd_mac(arp_rd_mac),
    .arp_rd_ip(arp_rd_ip), .arp_rd_ack(arp_rd_ack),
    .arp_wr_addr(arp_wr_addr), .arp_wr_req(arp_wr_req), .arp_wr_mac(arp_wr_mac),
    .arp_wr_ip(arp_wr_ip), .arp_wr_ack(arp_wr_ack)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic set_req(input int r, input logic wr, input logic [4:0] addr, input logic [47:0] mac,
                         input logic [31:0] ip);
    req_is_wr[r] = wr;
    req_addr[r*AW +: AW] = addr;
    req_wr_mac[r*48 +: 48] = mac;
    req_wr_ip[r*32 +: 32] = ip;
    req_valid[r] = 1'b1;
  endtask

  // Entered at a negedge with the arbiter idle; leaves at the negedge after the response.
  task automatic run_vec(input vec_t v);
    set_req(v.r, v.wr, v.addr, v.mac, v.ip);
    arp_rd_mac = v.tmac;
    arp_rd_ip = v.tip;
    @(negedge clk);
    check("issue_kind", {arp_rd_req, arp_wr_req}, {!v.wr, v.wr});
    check("issue_addr", v.wr ? arp_wr_addr : arp_rd_addr, v.addr);
    if (v.wr) check("issue_wdata", {arp_wr_mac, arp_wr_ip}, {v.mac, v.ip});
    for (int k = 1; k <= v.dly; k++) begin
      @(negedge clk);
      arp_rd_ack = 1'b0;
      arp_wr_ack = 1'b0;
      check("wait_quiet", {req_ack, arp_rd_req, arp_wr_req}, 0);
      check("wait_addr", v.wr ? arp_wr_addr : arp_rd_addr, v.addr);
      if (v.wr) check("wait_wdata", {arp_wr_mac, arp_wr_ip}, {v.mac, v.ip});
      if (v.stray && k == 1) begin
        if (v.wr) arp_rd_ack = 1'b1;
        else arp_wr_ack = 1'b1;
      end
      if (k == v.dly) begin
        if (v.wr) arp_wr_ack = 1'b1;
        else arp_rd_ack = 1'b1;
      end
    end
    @(negedge clk);
    arp_rd_ack = 1'b0;
    arp_wr_ack = 1'b0;
    req_valid[v.r] = 1'b0;
    check("resp_ack", req_ack, v.eack);
    check("resp_err", req_err, 0);
    check("resp_data", {rsp_rd_mac, rsp_rd_ip}, {v.emac, v.eip});
    @(negedge clk);
    check("post_ack", req_ack, 0);
    ptr_m = (v.r + 1) % N;
    last_rsp = {v.emac, v.eip};
  endtask

  // Cycle-stepped traffic: requesters post random transactions, a table model answers after a
  // random delay, and every grant is compared with the round-robin rule applied to the request set.
  task automatic run_traffic(input int n, input bit contend);
    int done, cur, cnt, g;
    bit busy, due;
    bit [N-1:0] drop;
    done = 0; cur = 0; cnt = 0; busy = 0; due = 0;
    for (int cyc = 0; cyc < 3000 && done < n; cyc++) begin
      drop = '0;
      @(negedge clk);
      arp_rd_ack = 1'b0;
      arp_wr_ack = 1'b0;
      check("ack_vec", req_ack, due ? 2'(1 << cur) : 2'b00);
      if (due) begin
        check("rsp_err", req_err, 0);
        if (!tx_wr[cur]) last_rsp = mem[tx_addr[cur]];
        check("rsp_data", {rsp_rd_mac, rsp_rd_ip}, last_rsp);
        ptr_m = (cur + 1) % N;
        req_valid[cur] = 1'b0;
        drop[cur] = 1'b1;
        busy = 0;
        due = 0;
        done++;
        if (contend) order.push_back(cur);
      end
      if (arp_rd_req || arp_wr_req) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        check("issue_idle", busy, 0);
        check("grant_found", g >= 0, 1);
        cur = (g < 0) ? 0 : g;
        check("issue_kind", {arp_rd_req, arp_wr_req}, {!tx_wr[cur], tx_wr[cur]});
        check("issue_addr", tx_wr[cur] ? arp_wr_addr : arp_rd_addr, tx_addr[cur]);
        if (tx_wr[cur]) check("issue_wdata", {arp_wr_mac, arp_wr_ip}, {tx_mac[cur], tx_ip[cur]});
        busy = 1;
        cnt = $urandom_range(1, 4);
      end else if (busy && cnt > 0) begin
        check("hold_addr", tx_wr[cur] ? arp_wr_addr : arp_rd_addr, tx_addr[cur]);
        cnt--;
        if (cnt == 0) begin
          if (tx_wr[cur]) begin
            mem[tx_addr[cur]] = {tx_mac[cur], tx_ip[cur]};
            arp_wr_ack = 1'b1;
          end else begin
            {arp_rd_mac, arp_rd_ip} = mem[tx_addr[cur]];
            arp_rd_ack = 1'b1;
          end
          due = 1;
        end else if ($urandom_range(0, 3) == 0) begin
          {arp_rd_mac, arp_rd_ip} = {48'(~64'(0)), $urandom()};
          if (tx_wr[cur]) arp_rd_ack = 1'b1;
          else arp_wr_ack = 1'b1;
        end
      end else if (!busy && $urandom_range(0, 7) == 0) begin
        arp_rd_ack = 1'b1;
      end
      for (int r = 0; r < N; r++) begin
        if (!req_valid[r] && !drop[r] && (contend || $urandom_range(0, 2) == 0)) begin
          tx_wr[r] = 1'($urandom_range(0, 1));
          tx_addr[r] = 5'($urandom_range(0, 31));
          tx_mac[r] = 48'({$urandom(), $urandom()});
          tx_ip[r] = $urandom();
          set_req(r, tx_wr[r], tx_addr[r], tx_mac[r], tx_ip[r]);
        end else if (req_valid[r] && !contend && !(busy && cur == r) && $urandom_range(0, 15) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
    end
    check("traffic_done", done, n);
    req_valid = '0;
    arp_rd_ack = 1'b0;
    arp_wr_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    req_valid = '0; req_is_wr = '0; req_addr = '0; req_wr_mac = '0; req_wr_ip = '0;
    arp_rd_mac = '0; arp_rd_ip = '0; arp_rd_ack = 1'b0; arp_wr_ack = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = {48'({$urandom(), $urandom()}), $urandom()};
    vecs[0] = '{0, 0, 5'd3, 48'h0, 32'h0, 2, 0, 48'h0011_2233_4455, 32'h0A00_0001,
                2'b01, 48'h0011_2233_4455, 32'h0A00_0001};
    vecs[1] = '{1, 1, 5'd31, 48'hAABB_CCDD_EEFF, 32'hC0A8_0101, 2, 0, 48'h1111_1111_1111, 32'h2222_2222,
                2'b10, 48'h0011_2233_4455, 32'h0A00_0001};
    vecs[2] = '{1, 0, 5'd0, 48'h0, 32'h0, 1, 0, 48'hDEAD_BEEF_0001, 32'h0102_0304,
                2'b10, 48'hDEAD_BEEF_0001, 32'h0102_0304};
    vecs[3] = '{0, 0, 5'd12, 48'h0, 32'h0, 3, 1, 48'h5A5A_5A5A_5A5A, 32'h1234_5678,
                2'b01, 48'h5A5A_5A5A_5A5A, 32'h1234_5678};
    vecs[4] = '{0, 1, 5'd7, 48'h0102_0304_0506, 32'h0A0B_0C0D, 3, 1, 48'h9999_9999_9999, 32'h8888_8888,
                2'b01, 48'h5A5A_5A5A_5A5A, 32'h1234_5678};
    vecs[5] = '{0, 0, 5'd31, 48'h0, 32'h0, 5, 0, 48'h1234_5678_9ABC, 32'hFFFF_FFFF,
                2'b01, 48'h1234_5678_9ABC, 32'hFFFF_FFFF};
    #3;
    check("rst_ctl", {req_ack, req_err, arp_rd_req, arp_wr_req}, 0);
    check("rst_rsp", {rsp_rd_mac, rsp_rd_ip}, 0);
    check("rst_wdata", {arp_wr_mac, arp_wr_ip}, 0);
    check("rst_addr", {arp_rd_addr, arp_wr_addr}, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_quiet", {req_ack, arp_rd_req, arp_wr_req}, 0);

    run_traffic(6, 1);
    check("rr_count", order.size(), 6);
    for (int k = 0; k < order.size() && k < 6; k++) check("rr_order", order[k], k % 2);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    arp_rd_ack = 1'b1;
    @(negedge clk);
    arp_rd_ack = 1'b0;
    check("idle_stray", {req_ack, arp_rd_req, arp_wr_req}, 0);
    @(negedge clk);
    check("idle_stray2", {req_ack, arp_rd_req, arp_wr_req}, 0);
    run_vec(vecs[2]);

    set_req(0, 1'b0, 5'd9, 48'h0, 32'h0);
    @(negedge clk);
    check("mid_issue", arp_rd_req, 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_ctl", {req_ack, req_err, arp_rd_req, arp_wr_req}, 0);
    check("mid_rst_rsp", {rsp_rd_mac, rsp_rd_ip}, 0);
    check("mid_rst_wdata", {arp_wr_mac, arp_wr_ip}, 0);
    check("mid_rst_addr", {arp_rd_addr, arp_wr_addr}, 0);
    req_valid = '0;
    @(negedge clk);
    resetn = 1'b1;
    arp_rd_ack = 1'b1;
    @(negedge clk);
    arp_rd_ack = 1'b0;
    check("mid_late_ack", {req_ack, arp_rd_req, arp_wr_req}, 0);
    @(negedge clk);
    check("mid_late_ack2", {req_ack, arp_rd_req, arp_wr_req}, 0);
    ptr_m = 0;
    last_rsp = '0;
    run_vec(vecs[0]);

    run_traffic(40, 0);

`ifdef ARP_TABLE_ARBITER_TIMEOUT_EN
    set_req(0, 1'b0, 5'd4, 48'h0, 32'h0);
    @(negedge clk);
    check("to_issue", arp_rd_req, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("to_wait", req_ack, 0);
    end
    @(negedge clk);
    req_valid = '0;
    check("to_ack", req_ack, 2'b01);
    check("to_err", req_err, 1);
    check("to_rsp", {rsp_rd_mac, rsp_rd_ip}, 0);
    arp_rd_ack = 1'b1;
    @(negedge clk);
    arp_rd_ack = 1'b0;
    check("to_late", {req_ack, req_err}, 0);
    @(negedge clk);
    check("to_late2", {req_ack, req_err, arp_rd_req}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
